// File: rtl/fp_pkg.sv
// Shared FP32 formats for the divider back end: raw-quotient and normalized-stage
// records, kind encoding, flag bit positions and IEEE constants.
package fp_pkg;

  typedef enum logic [1:0] {
    KIND_FINITE = 2'd0,
    KIND_ZERO   = 2'd1,
    KIND_INF    = 2'd2,
    KIND_NAN    = 2'd3
  } fp_kind_e;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIVZERO   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam int          FP_BIAS = 127;
  localparam int          EXP_MAX = 255;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] mant;
    logic        sticky;
    fp_kind_e    kind;
    logic [1:0]  flags;
  } fp_raw_t;

  // Significand after normalization/denormalization, ready for rounding.
  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic        tiny;
    fp_kind_e    kind;
    logic [1:0]  flags;
  } fp_norm_t;

  function automatic logic rne_increment(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even, carry handling, overflow saturation and
// IEEE single packing of a normalized significand.
module fp_round_rne
  import fp_pkg::*;
(
  input  fp_norm_t    norm,
  output logic [31:0] res,
  output logic [4:0]  flags
);

  logic [23:0] sum_s;
  logic [9:0]  exp_r_s;
  logic        inexact_s;

  always_comb begin
    sum_s     = {1'b0, norm.frac} + {23'd0, rne_increment(norm.frac[0], norm.guard, norm.sticky)};
    // A carry out leaves sum_s[22:0] at zero, which is the correct fraction.
    exp_r_s   = norm.exp + {9'd0, sum_s[23]};
    inexact_s = norm.guard | norm.sticky;
    res       = 32'd0;
    flags     = 5'd0;
    case (norm.kind)
      KIND_ZERO: res = {norm.sign, 31'd0};
      KIND_INF:  res = {norm.sign, 8'hFF, 23'd0};
      KIND_NAN:  res = FP_QNAN;
      default: begin
        if (exp_r_s >= 10'(EXP_MAX)) begin
          res                   = {norm.sign, 8'hFF, 23'd0};
          flags[FLAG_OVERFLOW]  = 1'b1;
          flags[FLAG_INEXACT]   = 1'b1;
        end else begin
          res                   = {norm.sign, exp_r_s[7:0], sum_s[22:0]};
          flags[FLAG_UNDERFLOW] = norm.tiny & inexact_s;
          flags[FLAG_INEXACT]   = inexact_s;
        end
      end
    endcase
    flags[FLAG_INVALID] = norm.flags[1];
    flags[FLAG_DIVZERO] = norm.flags[0];
  end

endmodule

// File: rtl/fp_div_post_norm.sv
// Two-stage elastic normalize/round/pack stage behind the Newton-Raphson FP32
// divider: stage 1 normalizes or denormalizes, stage 2 rounds and registers the result.
module fp_div_post_norm
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [26:0] in_mant,
  input  logic        in_sticky,
  input  logic [1:0]  in_kind,
  input  logic [1:0]  in_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic [4:0]  out_flags
);

  fp_raw_t            raw_s;
  fp_norm_t           norm_s;
  logic [22:0]        frac_s;
  logic               guard_s;
  logic               sticky_s;
  logic signed [10:0] e_s;
  logic signed [10:0] sh_full_s;
  logic [4:0]         sh_m1_s;
  logic [48:0]        ext_s;
  logic [48:0]        shf_s;

  logic        s1_valid_q, s1_valid_d;
  fp_norm_t    s1_q, s1_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_q, out_d;
  logic [4:0]  out_flags_q, out_flags_d;
  logic        s2_advance;
  logic [31:0] rnd_res_s;
  logic [4:0]  rnd_flags_s;

  always_comb begin
    raw_s = '{sign: in_sign, exp: in_exp, mant: in_mant, sticky: in_sticky,
              kind: fp_kind_e'(in_kind), flags: in_flags};
    if (raw_s.mant[26]) begin
      frac_s   = raw_s.mant[25:3];
      guard_s  = raw_s.mant[2];
      sticky_s = (|raw_s.mant[1:0]) | raw_s.sticky;
      e_s      = $signed({raw_s.exp[9], raw_s.exp});
    end else begin
      frac_s   = raw_s.mant[24:2];
      guard_s  = raw_s.mant[1];
      sticky_s = raw_s.mant[0] | raw_s.sticky;
      e_s      = $signed({raw_s.exp[9], raw_s.exp}) - 11'sd1;
    end
    // Denormal shift is 1-e capped at 25; the vector below is pre-shifted by one.
    sh_full_s = 11'sd1 - e_s;
    sh_m1_s   = (sh_full_s > 11'sd25) ? 5'd24 : (sh_full_s[4:0] - 5'd1);
    ext_s     = {1'b1, frac_s, guard_s, 24'd0};
    shf_s     = ext_s >> sh_m1_s;

    norm_s.sign  = raw_s.sign;
    norm_s.kind  = raw_s.kind;
    norm_s.flags = raw_s.flags;
    if ((raw_s.kind == KIND_FINITE) && (e_s <= 11'sd0)) begin
      norm_s.frac   = shf_s[48:26];
      norm_s.guard  = shf_s[25];
      norm_s.sticky = sticky_s | (|shf_s[24:0]);
      norm_s.exp    = 10'd0;
      norm_s.tiny   = 1'b1;
    end else begin
      norm_s.frac   = frac_s;
      norm_s.guard  = guard_s;
      norm_s.sticky = sticky_s;
      norm_s.exp    = e_s[9:0];
      norm_s.tiny   = 1'b0;
    end
  end

  fp_round_rne u_round (
    .norm  (s1_q),
    .res   (rnd_res_s),
    .flags (rnd_flags_s)
  );

  assign s2_advance = !out_valid_q | out_ready;
  assign in_ready   = !s1_valid_q | s2_advance;

  // Next-state for both stages; each stage reloads only when its downstream drains.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_flags_d = out_flags_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = norm_s;
      end else begin
        s1_d = s1_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d       = rnd_res_s;
        out_flags_d = rnd_flags_s;
      end else begin
        out_d       = out_q;
        out_flags_d = out_flags_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= 32'd0;
      out_flags_q <= 5'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_flags_q <= out_flags_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_div_post_norm.sv
// Self-checking bench for fp_div_post_norm: directed vectors, backpressure,
// randomized streaming against an arithmetic reference model, and mid-stream reset.
module tb_fp_div_post_norm;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [26:0] in_mant;
  logic        in_sticky;
  logic [1:0]  in_kind;
  logic [1:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [4:0]  out_flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_div_post_norm dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_sticky (in_sticky),
    .in_kind   (in_kind),
    .in_flags  (in_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_flags (out_flags)
  );

  // Value = mant * 2^(exp-127-26). Express it in units of the result ulp, round
  // to nearest even, then pack as (biased exponent - 1) * 2^23 + integer significand.
  function automatic logic [36:0] ref_model(input fp_raw_t b);
    logic [31:0] r;
    logic [4:0]  f;
    int          exs, e_n, eu, sh;
    longint      mm, q, rem, half, mag;
    logic        tiny, inexact, rup;
    f = {b.flags, 3'b000};
    r = 32'd0;
    case (b.kind)
      KIND_ZERO: r = {b.sign, 31'd0};
      KIND_INF:  r = {b.sign, 8'hFF, 23'd0};
      KIND_NAN:  r = 32'h7FC0_0000;
      default: begin
        exs  = int'($signed(b.exp));
        e_n  = b.mant[26] ? exs : exs - 1;
        tiny = (e_n <= 0);
        eu   = tiny ? 1 : e_n;
        sh   = eu - exs + 3;
        if (sh > 60) sh = 60;
        mm   = longint'(b.mant);
        q    = mm >> sh;
        rem  = mm - (q << sh);
        half = longint'(1) << (sh - 1);
        inexact = (rem != 0) || b.sticky;
        rup  = (rem > half) || ((rem == half) && (b.sticky || q[0]));
        q    = q + (rup ? 1 : 0);
        mag  = (longint'(eu - 1) << 23) + q;
        if (mag >= (longint'(EXP_MAX) << 23)) begin
          r = {b.sign, 8'hFF, 23'd0};
          f[2] = 1'b1;
          f[0] = 1'b1;
        end else begin
          r = {b.sign, mag[30:0]};
          f[1] = tiny & inexact;
          f[0] = inexact;
        end
      end
    endcase
    return {f, r};
  endfunction

  function automatic fp_raw_t rand_beat();
    fp_raw_t b;
    int      exs, sel;
    sel = $urandom_range(99, 0);
    if (sel < 35)      exs = $urandom_range(532, 0) - 150;
    else if (sel < 65) exs = $urandom_range(40, 0) - 30;
    else               exs = $urandom_range(20, 0) + 240;
    b.sign   = 1'($urandom_range(1, 0));
    b.exp    = 10'(exs);
    b.mant   = 27'($urandom);
    b.sticky = 1'($urandom_range(1, 0));
    if ($urandom_range(1, 0) == 1) begin
      b.mant[26] = 1'b1;
      if ($urandom_range(3, 0) == 0) begin
        b.mant[2:0] = 3'b100;
        b.sticky    = 1'b0;
      end
    end else begin
      b.mant[26] = 1'b0;
      b.mant[25] = 1'b1;
    end
    b.kind  = (sel % 10 == 9) ? fp_kind_e'(2'($urandom_range(3, 1))) : KIND_FINITE;
    b.flags = 2'($urandom_range(3, 0));
    return b;
  endfunction

  task automatic drive(input fp_raw_t b);
    in_sign   = b.sign;
    in_exp    = b.exp;
    in_mant   = b.mant;
    in_sticky = b.sticky;
    in_kind   = b.kind;
    in_flags  = b.flags;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive('0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out !== 32'd0 || out_flags !== 5'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: got valid=%b out=%h flags=%b in_ready=%b, want 0/00000000/00000/1",
               out_valid, out, out_flags, in_ready);
    end
  endtask

  task automatic test_directed();
    fp_raw_t     v[11];
    logic [31:0] eo[11];
    logic [4:0]  ef[11];
    v[0]  = '{1'b0, 10'd128, 27'h4000000, 1'b0, KIND_FINITE, 2'b00}; eo[0]  = 32'h40000000; ef[0]  = 5'b00000;
    v[1]  = '{1'b0, 10'd126, 27'h2AAAAAA, 1'b1, KIND_FINITE, 2'b00}; eo[1]  = 32'h3EAAAAAB; ef[1]  = 5'b00001;
    v[2]  = '{1'b0, 10'd255, 27'h4000000, 1'b0, KIND_FINITE, 2'b00}; eo[2]  = 32'h7F800000; ef[2]  = 5'b00101;
    v[3]  = '{1'b0, 10'd0,   27'h2000000, 1'b0, KIND_FINITE, 2'b00}; eo[3]  = 32'h00200000; ef[3]  = 5'b00000;
    v[4]  = '{1'b0, 10'd0,   27'h7FFFFFF, 1'b1, KIND_FINITE, 2'b00}; eo[4]  = 32'h00800000; ef[4]  = 5'b00011;
    v[5]  = '{1'b1, 10'd0,   27'h0,       1'b0, KIND_NAN,    2'b00}; eo[5]  = 32'h7FC00000; ef[5]  = 5'b00000;
    v[6]  = '{1'b1, 10'd0,   27'h0,       1'b0, KIND_INF,    2'b01}; eo[6]  = 32'hFF800000; ef[6]  = 5'b01000;
    v[7]  = '{1'b0, 10'd0,   27'h4000000, 1'b0, KIND_FINITE, 2'b00}; eo[7]  = 32'h00400000; ef[7]  = 5'b00000;
    v[8]  = '{1'b0, 10'd127, 27'h4000004, 1'b0, KIND_FINITE, 2'b00}; eo[8]  = 32'h3F800000; ef[8]  = 5'b00001;
    v[9]  = '{1'b0, 10'd127, 27'h400000C, 1'b0, KIND_FINITE, 2'b00}; eo[9]  = 32'h3F800002; ef[9]  = 5'b00001;
    v[10] = '{1'b1, 10'd5,   27'h0,       1'b0, KIND_ZERO,   2'b10}; eo[10] = 32'h80000000; ef[10] = 5'b10000;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(v[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_latency1: out_valid=%b want 0 one cycle after accept", i, out_valid);
      end
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b1 || out !== eo[i] || out_flags !== ef[i]) begin
        failures++;
        $display("FAIL dir%0d_result: got valid=%b out=%h flags=%b, want 1/%h/%b",
                 i, out_valid, out, out_flags, eo[i], ef[i]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    fp_raw_t     b[3];
    logic [36:0] e[3];
    for (int i = 0; i < 3; i++) begin
      b[i] = rand_beat();
      e[i] = ref_model(b[i]);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(b[i]);
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL bp_accept%0d: in_ready=%b want 1", i, in_ready);
      end
      tick();
    end
    drive(b[2]);
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: in_ready=%b want 0 with two beats held", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || {out_flags, out} !== e[0] || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall%0d: got valid=%b res=%h in_ready=%b, want 1/%h/0",
                 c, out_valid, {out_flags, out}, in_ready, e[0]);
      end
      tick();
      #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || {out_flags, out} !== e[0]) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b res=%h, want 1/%h", in_ready, {out_flags, out}, e[0]);
    end
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || {out_flags, out} !== e[i]) begin
        failures++;
        $display("FAIL bp_order%0d: got valid=%b res=%h, want 1/%h", i, out_valid, {out_flags, out}, e[i]);
      end
      tick();
    end
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_random_stream();
    logic [36:0] exp_q[$];
    fp_raw_t     cur;
    int          sent, recv, cyc;
    logic        held;
    logic [36:0] held_res;
    sent = 0; recv = 0; cyc = 0; held = 1'b0; held_res = '0;
    cur = rand_beat();
    while ((sent < 400 || recv < 400) && cyc < 5000) begin
      tick();
      cyc++;
      drive(cur);
      in_valid  = (sent < 400) && ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(9, 0) < 7);
      #1;
      if (held && out_valid) begin
        checks++;
        if ({out_flags, out} !== held_res) begin
          failures++;
          $display("FAIL rand_stable: res=%h changed while stalled, want %h", {out_flags, out}, held_res);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra: unexpected beat res=%h, want none", {out_flags, out});
        end else begin
          if ({out_flags, out} !== exp_q[0]) begin
            failures++;
            $display("FAIL rand_beat%0d: got res=%h, want %h", recv, {out_flags, out}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        recv++;
      end
      held     = out_valid && !out_ready;
      held_res = {out_flags, out};
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(cur));
        sent++;
        cur = rand_beat();
      end
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 400 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_complete: received %0d pending %0d, want 400 received 0 pending",
               recv, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(rand_beat());
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_pre_full: valid=%b in_ready=%b, want 1/0", out_valid, in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 32'd0 || out_flags !== 5'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_async_flush: valid=%b out=%h flags=%b in_ready=%b, want 0/00000000/00000/1",
               out_valid, out, out_flags, in_ready);
    end
    tick();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_stale%0d: out_valid=%b out=%h, want 0", c, out_valid, out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random_stream();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
